// File: rtl/count_uart_pkg.sv
// count_uart_pkg: shared types and constants for the count UART reporter.
// Holds the controller state enum, the ASCII bytes of the report, the
// message length and the double-dabble step used for BCD conversion.
package count_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_U  = 8'h55;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int MSG_LEN     = 8;
  localparam int CONV_CYCLES = 14;

  localparam logic [13:0] COUNT_MAX = 14'd9999;

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add 3 to every
  // BCD digit that is 5 or more, then shift the whole vector left by one.
  function automatic logic [29:0] dabble_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      if (t[14 + 4*d +: 4] >= 4'd5) begin
        t[14 + 4*d +: 4] = t[14 + 4*d +: 4] + 4'd3;
      end
    end
    return {t[28:0], 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 byte serializer. A start pulse while idle latches the
// byte; the frame (start, 8 data bits LSB first, stop) is shifted out with
// each bit held DIV clocks. done pulses for one cycle when the stop bit ends.
// Handshake: start is accepted only in a cycle where busy is low; busy stays
// high from the accepting edge until the stop bit has been held DIV cycles.
module uart_tx_core #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;

  // Serializer: latch the frame on start, advance one bit every DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      frame    <= '1;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          frame    <= {1'b1, data, 1'b0};
          tx       <= 1'b0;
          busy     <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      end else if (baud_cnt == CW'(DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
          done <= 1'b1;
          tx   <= 1'b1;
        end else begin
          frame   <= {1'b1, frame[9:1]};
          tx      <= frame[1];
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/count_uart_reporter.sv
// count_uart_reporter: on a send request, captures count/mode/run_stop,
// converts count (clamped to 9999) to BCD with 14 double-dabble steps and
// transmits the 8-byte report "<U|D>dddd<R|S>\r\n" over an 8N1 UART.
// Optional feature: define COUNT_UART_AUTO_REPORT_EN to also start a report
// from IDLE whenever count differs from the last reported value.
// state_dbg exposes the controller state (count_uart_pkg::state_t encoding).
module count_uart_reporter
  import count_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send,
  input  logic [13:0] count,
  input  logic        mode,
  input  logic        run_stop,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [2:0]  state_dbg
);

  localparam int DIV = CLK_FREQ / BAUD;

  state_t      state;
  logic [29:0] work;
  logic [3:0]  conv_cnt;
  logic [2:0]  idx;
  logic        mode_q;
  logic        run_q;
  logic        core_start;
  logic        core_busy;
  logic        core_done;
  logic [7:0]  byte_sel;
  logic        start_req;

  assign state_dbg = state;

`ifdef COUNT_UART_AUTO_REPORT_EN
  logic [13:0] last_val;

  assign start_req = send || (count != last_val);

  // Remember the count captured for the most recent report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_val <= '0;
    end else if (state == ST_IDLE && start_req) begin
      last_val <= count;
    end
  end
`else
  assign start_req = send;
`endif

  // Byte for the current message index; digits come from the BCD field.
  always_comb begin
    byte_sel = ASCII_LF;
    case (idx)
      3'd0:    byte_sel = mode_q ? ASCII_D : ASCII_U;
      3'd1:    byte_sel = ASCII_0 + {4'd0, work[29:26]};
      3'd2:    byte_sel = ASCII_0 + {4'd0, work[25:22]};
      3'd3:    byte_sel = ASCII_0 + {4'd0, work[21:18]};
      3'd4:    byte_sel = ASCII_0 + {4'd0, work[17:14]};
      3'd5:    byte_sel = run_q ? ASCII_R : ASCII_S;
      3'd6:    byte_sel = ASCII_CR;
      default: byte_sel = ASCII_LF;
    endcase
  end

  // Report controller: capture, convert, then hand bytes to the serializer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      work       <= '0;
      conv_cnt   <= '0;
      idx        <= '0;
      mode_q     <= 1'b0;
      run_q      <= 1'b0;
      core_start <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            work     <= {16'd0, (count > COUNT_MAX) ? COUNT_MAX : count};
            mode_q   <= mode;
            run_q    <= run_stop;
            conv_cnt <= '0;
            idx      <= '0;
            tx_busy  <= 1'b1;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          work     <= dabble_step(work);
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'(CONV_CYCLES - 1)) begin
            core_start <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            if (idx < 3'(MSG_LEN - 1)) begin
              idx        <= idx + 3'd1;
              core_start <= 1'b1;
              state      <= ST_SEND;
            end else begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_core #(
    .DIV(DIV)
  ) u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (core_start & ~core_busy),
    .data    (byte_sel),
    .tx      (tx),
    .busy    (core_busy),
    .done    (core_done)
  );

endmodule
